latency_memory: RTL and testbench

Memory-side responder for the TSC pipeline's instruction and data ports. It models a fixed-latency main memory: it accepts one request at a time from either the I-port (fetch) or the D-port (load/store), waits `LATENCY` cycles, then returns data with a one-cycle ready pulse. It is the counterpart of the pipeline's stall/latency logic: the core holds its request until ready, and this block decides when ready fires.

---
 rtl/latency_memory_pkg.sv | 27 ++
 rtl/latency_memory_if.sv | 44 ++++
 rtl/latency_memory_counter.sv | 32 +++
 rtl/latency_memory.sv | 168 ++++++++++++++++
 tb/tb_latency_memory.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/latency_memory_pkg.sv
// -----------------------------------------------------------------------------
// latency_memory_pkg
// Shared constants for the fixed-latency memory responder. The core's stall
// logic imports the same DEFAULT_LATENCY, so both ends of the handshake agree
// on when ready fires.
//   - FSM state encodings (IDLE / BUSY_I / BUSY_D / RESP)
//   - default latency, word, address and depth sizes
//   - cnt_width(): width of the latency counter for a given latency
// -----------------------------------------------------------------------------
package latency_memory_pkg;

   localparam int DEFAULT_LATENCY    = 4;
   localparam int DEFAULT_WORD_WIDTH = 16;
   localparam int DEFAULT_ADDR_WIDTH = 16;
   localparam int DEFAULT_MEM_DEPTH  = 256;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // One extra bit over $clog2 keeps LATENCY=1 at a legal 1-bit counter.
   function automatic int cnt_width(input int latency);
      return $clog2(latency) + 1;
   endfunction

endpackage

// File: rtl/latency_memory_if.sv
// -----------------------------------------------------------------------------
// latency_memory_if
// Request/response bundle between the pipeline (master) and latency_memory
// (slave).
//
// Handshake: a request (i_readM, or d_readM/d_writeM) is a level held by the
// master. The slave accepts it at the first clock edge where it is idle and
// latches every request field, so address/data may change afterwards. The
// slave answers with a one-cycle ready pulse (i_ready / d_ready); the
// accompanying data is valid only while ready is high. The master drops its
// request in the cycle after ready unless it wants another access; a request
// still high when the slave is idle again is a new request. i_abort cancels
// a fetch that is waiting for its latency to expire.
//
// Signals: i_readM, i_address, i_abort, i_data, i_ready   (fetch port)
//          d_readM, d_writeM, d_address, d_wdata, d_rdata, d_ready (data port)
// -----------------------------------------------------------------------------
interface latency_memory_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  i_readM;
   logic [ADDR_WIDTH-1:0] i_address;
   logic                  i_abort;
   logic [WORD_WIDTH-1:0] i_data;
   logic                  i_ready;

   logic                  d_readM;
   logic                  d_writeM;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [WORD_WIDTH-1:0] d_wdata;
   logic [WORD_WIDTH-1:0] d_rdata;
   logic                  d_ready;

   modport master (
      output i_readM, i_address, i_abort, d_readM, d_writeM, d_address, d_wdata,
      input  i_data, i_ready, d_rdata, d_ready
   );

   modport slave (
      input  i_readM, i_address, i_abort, d_readM, d_writeM, d_address, d_wdata,
      output i_data, i_ready, d_rdata, d_ready
   );
endinterface

// File: rtl/latency_memory_counter.sv
// -----------------------------------------------------------------------------
// latency_counter
// Counts wait cycles of an accepted request.
//   clk, reset_n : clock, synchronous active-low reset
//   i_clear      : load count to zero (acceptance, abort, idle)
//   i_inc        : advance the count by one
//   o_done       : count has reached LATENCY-1
// -----------------------------------------------------------------------------
module latency_counter
   import latency_memory_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int CW      = cnt_width(LATENCY)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_done
);
   logic [CW-1:0] r_count;

   assign o_done = (r_count == CW'(LATENCY - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CW'(1);
      end
   end
endmodule

// File: rtl/latency_memory.sv
// -----------------------------------------------------------------------------
// latency_memory
// Fixed-latency main-memory model serving one request at a time from the
// fetch port or the data port. An accepted request waits LATENCY cycles and
// is answered by a one-cycle registered ready pulse. D requests win over I
// requests in IDLE; a store commits on the edge entering RESP.
//
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   bus (slave)   : latency_memory_if request/response bundle
//   o_state       : current FSM state (debug)
//   num_i_access  : completed fetches (MEM_STATS_EN only)
//   num_d_access  : completed loads/stores (MEM_STATS_EN only)
//
// Build option: define MEM_STATS_EN to add the saturating access counters.
// -----------------------------------------------------------------------------
module latency_memory
   import latency_memory_pkg::*;
#(
   parameter int LATENCY    = DEFAULT_LATENCY,
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   latency_memory_if.slave   bus,
   output logic [1:0]        o_state
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       num_i_access,
   output logic [15:0]       num_d_access
`endif
);
   localparam int IW = $clog2(MEM_DEPTH);

   logic [1:0]            r_state;
   logic [IW-1:0]         r_addr;
   logic [WORD_WIDTH-1:0] r_wdata;
   logic                  r_is_write;
   logic                  r_i_ready;
   logic                  r_d_ready;
   logic [WORD_WIDTH-1:0] r_i_data;
   logic [WORD_WIDTH-1:0] r_d_rdata;
   logic [WORD_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic w_d_req;
   logic w_busy;
   logic w_abort;
   logic w_done;
   logic w_cnt_clear;
   logic w_cnt_inc;
   logic w_i_complete;
   logic w_d_complete;
   logic w_mem_we;
   logic w_unused_addr_hi;

   // Upper address bits are deliberately dropped: addresses wrap on depth.
   assign w_unused_addr_hi = ^{bus.i_address[ADDR_WIDTH-1:IW], bus.d_address[ADDR_WIDTH-1:IW]};

   assign w_d_req      = bus.d_readM | bus.d_writeM;
   assign w_busy       = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
   assign w_abort      = (r_state == ST_BUSY_I) && bus.i_abort;
   // Abort beats the final wait cycle, so a fetch only completes without it.
   assign w_i_complete = (r_state == ST_BUSY_I) && !bus.i_abort && w_done;
   assign w_d_complete = (r_state == ST_BUSY_D) && w_done;
   assign w_cnt_clear  = !w_busy || w_abort;
   assign w_cnt_inc    = w_busy && !w_done;
   // Gated by reset so a store in flight at a reset edge never lands.
   assign w_mem_we     = reset_n && w_d_complete && r_is_write;

   assign o_state     = r_state;
   assign bus.i_ready = r_i_ready;
   assign bus.d_ready = r_d_ready;
   assign bus.i_data  = r_i_data;
   assign bus.d_rdata = r_d_rdata;

   latency_counter #(
      .LATENCY (LATENCY)
   ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (w_cnt_clear),
      .i_inc   (w_cnt_inc),
      .o_done  (w_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_is_write <= 1'b0;
         r_i_ready  <= 1'b0;
         r_d_ready  <= 1'b0;
         r_i_data   <= '0;
         r_d_rdata  <= '0;
      end else begin
         // Ready and data are pulses: cleared unless this edge enters RESP.
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
         r_i_data  <= '0;
         r_d_rdata <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_d_req) begin
                  r_state    <= ST_BUSY_D;
                  r_addr     <= bus.d_address[IW-1:0];
                  r_wdata    <= bus.d_wdata;
                  r_is_write <= bus.d_writeM;  // read+write together is a store
               end else if (bus.i_readM && !bus.i_abort) begin
                  r_state    <= ST_BUSY_I;
                  r_addr     <= bus.i_address[IW-1:0];
                  r_is_write <= 1'b0;
               end
            end
            ST_BUSY_I: begin
               if (bus.i_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_done) begin
                  r_state   <= ST_RESP;
                  r_i_ready <= 1'b1;
                  r_i_data  <= r_mem[r_addr];
               end
            end
            ST_BUSY_D: begin
               if (w_done) begin
                  r_state   <= ST_RESP;
                  r_d_ready <= 1'b1;
                  r_d_rdata <= r_is_write ? '0 : r_mem[r_addr];
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Array has no reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

`ifdef MEM_STATS_EN
   logic [15:0] r_num_i;
   logic [15:0] r_num_d;

   assign num_i_access = r_num_i;
   assign num_d_access = r_num_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_num_i <= '0;
         r_num_d <= '0;
      end else begin
         if (w_i_complete && (r_num_i != 16'hFFFF)) begin
            r_num_i <= r_num_i + 16'd1;
         end
         if (w_d_complete && (r_num_d != 16'hFFFF)) begin
            r_num_d <= r_num_d + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_latency_memory.sv
module tb_latency_memory;
   import latency_memory_pkg::*;

   localparam int LAT   = 4;
   localparam int DEPTH = 256;

   logic       clk;
   logic       reset_n;
   logic [1:0] o_state;
`ifdef MEM_STATS_EN
   logic [15:0] num_i_access;
   logic [15:0] num_d_access;
`endif

   latency_memory_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) bus ();

   latency_memory #(
      .LATENCY    (LAT),
      .WORD_WIDTH (16),
      .ADDR_WIDTH (16),
      .MEM_DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .o_state      (o_state)
`ifdef MEM_STATS_EN
      ,
      .num_i_access (num_i_access),
      .num_d_access (num_d_access)
`endif
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard and reference model
   logic [15:0] exp_q[$];
   logic [15:0] model_mem [DEPTH];
   int          model_i_cnt;
   int          model_d_cnt;
   int          n_assert;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.i_readM   = 1'b0;
      bus.i_abort   = 1'b0;
      bus.i_address = '0;
      bus.d_readM   = 1'b0;
      bus.d_writeM  = 1'b0;
      bus.d_address = '0;
      bus.d_wdata   = '0;
   endtask

   // One access from IDLE: request driven before E0, ready expected exactly
   // LAT edges later, request dropped right after ready. Address and write
   // data are scrambled after acceptance to prove they were latched.
   task automatic access(input bit is_d, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
      int idx;
      bit is_store;
      logic [15:0] got;
      idx      = int'(addr) % DEPTH;
      is_store = is_d && wr;
      @(negedge clk);
      if (is_d) begin
         bus.d_readM   = rd;
         bus.d_writeM  = wr;
         bus.d_address = addr;
         bus.d_wdata   = wdata;
      end else begin
         bus.i_readM   = 1'b1;
         bus.i_address = addr;
      end
      exp_q.push_back(is_store ? 16'h0000 : model_mem[idx]);
      @(posedge clk);  // E0
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk);
         #1;
         if (is_d) begin
            chk("d_ready", 32'(bus.d_ready), 32'(k == LAT));
            chk("i_ready_quiet", 32'(bus.i_ready), 32'd0);
         end else begin
            chk("i_ready", 32'(bus.i_ready), 32'(k == LAT));
            chk("d_ready_quiet", 32'(bus.d_ready), 32'd0);
         end
         if (k == 1) begin
            bus.d_address = 16'($urandom);
            bus.d_wdata   = 16'($urandom);
            bus.i_address = 16'($urandom);
         end
         if (k == LAT) begin
            got = is_d ? bus.d_rdata : bus.i_data;
            chk(is_d ? (is_store ? "store_rdata" : "load_data") : "fetch_data",
                32'(got), 32'(exp_q.pop_front()));
            if (is_store) model_mem[idx] = wdata;
            if (is_d) model_d_cnt++; else model_i_cnt++;
            idle_inputs();
         end
      end
   endtask

   initial begin
      logic [15:0] a, w, old;
      n_assert    = 0;
      n_fail      = 0;
      model_i_cnt = 0;
      model_d_cnt = 0;
      idle_inputs();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_i_ready", 32'(bus.i_ready), 32'd0);
      chk("reset_d_ready", 32'(bus.d_ready), 32'd0);
      chk("reset_i_data", 32'(bus.i_data), 32'd0);
      chk("reset_d_rdata", 32'(bus.d_rdata), 32'd0);
      chk("reset_state", 32'(o_state), 32'(ST_IDLE));
      reset_n = 1'b1;

      // preload the whole array through the data port
      for (int i = 0; i < DEPTH; i++) access(1, 0, 1, 16'(i), 16'($urandom));

      // fetch of a known word
      access(1, 0, 1, 16'h0010, 16'h1234);
      access(0, 1, 0, 16'h0010, 16'h0000);
      chk("fetch_0x10_model", 32'(model_mem[16'h10]), 32'h1234);

      // store then load
      access(1, 0, 1, 16'h0020, 16'hBEEF);
      access(1, 1, 0, 16'h0020, 16'h0000);

      // read+write together is a store
      access(1, 1, 1, 16'h0021, 16'hA5A5);
      access(1, 1, 0, 16'h0021, 16'h0000);

      // address wraps on depth
      access(1, 0, 1, 16'h1022, 16'h7E57);
      access(0, 1, 0, 16'h0022, 16'h0000);
      access(1, 1, 0, 16'hFF22, 16'h0000);

      // simultaneous I and D: D first, then I after the IDLE turnaround
      @(negedge clk);
      bus.i_readM   = 1'b1;
      bus.i_address = 16'h0050;
      bus.d_readM   = 1'b1;
      bus.d_address = 16'h0060;
      @(posedge clk);  // E0
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk);
         #1;
         chk("both_d_ready", 32'(bus.d_ready), 32'(k == LAT));
         chk("both_i_wait", 32'(bus.i_ready), 32'd0);
         if (k == LAT) begin
            chk("both_d_data", 32'(bus.d_rdata), 32'(model_mem[16'h60]));
            bus.d_readM = 1'b0;
            model_d_cnt++;
         end
      end
      @(posedge clk);  // E6: fetch accepted
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk);
         #1;
         chk("both_i_ready", 32'(bus.i_ready), 32'(k == LAT));
         if (k == LAT) begin
            chk("both_i_data", 32'(bus.i_data), 32'(model_mem[16'h50]));
            bus.i_readM = 1'b0;
            model_i_cnt++;
         end
      end

      // abort at E2, new fetch accepted at E3
      @(negedge clk);
      bus.i_readM   = 1'b1;
      bus.i_address = 16'h0030;
      @(posedge clk);  // E0
      @(posedge clk);  // E1
      #1;
      chk("abort_e1_ready", 32'(bus.i_ready), 32'd0);
      bus.i_abort = 1'b1;
      @(posedge clk);  // E2
      #1;
      chk("abort_state_idle", 32'(o_state), 32'(ST_IDLE));
      chk("abort_no_ready", 32'(bus.i_ready), 32'd0);
      bus.i_abort = 1'b0;
      access(0, 1, 0, 16'h0040, 16'h0000);  // accepted at E3

      // abort on the same edge as the transition to RESP
      @(negedge clk);
      bus.i_readM   = 1'b1;
      bus.i_address = 16'h0041;
      @(posedge clk);  // E0
      for (int k = 1; k <= LAT - 1; k++) @(posedge clk);
      #1;
      bus.i_abort = 1'b1;
      bus.i_readM = 1'b0;
      @(posedge clk);  // E(LAT)
      #1;
      chk("late_abort_no_ready", 32'(bus.i_ready), 32'd0);
      chk("late_abort_idle", 32'(o_state), 32'(ST_IDLE));
      bus.i_abort = 1'b0;

      // random mix
      for (int n = 0; n < 60; n++) begin
         a = 16'($urandom);
         w = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       access(0, 1, 0, a, w);
            1:       access(1, 1, 0, a, w);
            2:       access(1, 0, 1, a, w);
            default: access(1, 1, 1, a, w);
         endcase
      end

`ifdef MEM_STATS_EN
      chk("stats_i", 32'(num_i_access), 32'(model_i_cnt));
      chk("stats_d", 32'(num_d_access), 32'(model_d_cnt));
`endif

      // reset in the middle of a store: nothing committed
      old = model_mem[16'h70];
      @(negedge clk);
      bus.d_writeM  = 1'b1;
      bus.d_address = 16'h0070;
      bus.d_wdata   = ~old;
      @(posedge clk);  // E0
      @(posedge clk);  // E1
      #1;
      reset_n      = 1'b0;
      bus.d_writeM = 1'b0;
      @(posedge clk);  // E2
      #1;
      chk("rst_mid_d_ready", 32'(bus.d_ready), 32'd0);
      chk("rst_mid_i_ready", 32'(bus.i_ready), 32'd0);
      chk("rst_mid_d_rdata", 32'(bus.d_rdata), 32'd0);
      chk("rst_mid_i_data", 32'(bus.i_data), 32'd0);
      chk("rst_mid_state", 32'(o_state), 32'(ST_IDLE));
`ifdef MEM_STATS_EN
      chk("rst_stats_i", 32'(num_i_access), 32'd0);
      chk("rst_stats_d", 32'(num_d_access), 32'd0);
      model_i_cnt = 0;
      model_d_cnt = 0;
`endif
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk("rst_hold_d_ready", 32'(bus.d_ready), 32'd0);
      reset_n = 1'b1;
      access(1, 1, 0, 16'h0070, 16'h0000);
      chk("rst_word_unchanged", 32'(model_mem[16'h70]), 32'(old));

`ifdef MEM_STATS_EN
      access(0, 1, 0, 16'h0001, 16'h0000);
      chk("stats_i_after_rst", 32'(num_i_access), 32'(model_i_cnt));
      chk("stats_d_after_rst", 32'(num_d_access), 32'(model_d_cnt));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
